// File: rtl/cs_measure_engine_pkg.sv
// Shared constants, state encoding and LFSR step rule for the compressive-sensing measurement engine.
package cs_measure_engine_pkg;

  localparam int N      = 64;
  localparam int M      = 16;
  localparam int DATA_W = 8;
  localparam int ACC_W  = DATA_W + $clog2(N) + 1;
  localparam int PTR_W  = $clog2(N);
  localparam int ROW_W  = $clog2(M);

  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    EMIT    = 2'd2
  } state_t;

  // Galois right-shift step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/cs_lfsr16.sv
// 16-bit Galois LFSR generating the +/-1 measurement matrix; reloadable with a seed.
module cs_lfsr16
  import cs_measure_engine_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state,
  output logic        bit_out
);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= RESET_SEED;
    else if (load) state <= seed;
    else if (step) state <= lfsr_next(state);
  end

  assign bit_out = state[0];

endmodule

// File: rtl/cs_measure_engine.sv
// Buffers a frame of N samples, then streams M signed measurements y[m] = sum phi[m][n]*x[n].
module cs_measure_engine
  import cs_measure_engine_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [PTR_W-1:0] LAST_COL = PTR_W'(N - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);

  state_t                    state;
  logic [DATA_W-1:0]         sample_buf [N];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   mac_sum;
  logic                      frame_done;
  logic                      phi_bit;
  logic [15:0]               lfsr_state;
  logic                      unused_lfsr;

  assign frame_done  = (state == LOAD) && in_valid && (wr_ptr == LAST_COL);
  assign sample_ext  = $signed({{(ACC_W-DATA_W){1'b0}}, sample_buf[col]});
  assign mac_sum     = phi_bit ? (acc + sample_ext) : (acc - sample_ext);
  assign unused_lfsr = ^lfsr_state;

  // Reseeded on every frame so each frame sees the same matrix.
  cs_lfsr16 #(.RESET_SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (frame_done),
    .step    (state == COMPUTE),
    .seed    (SEED),
    .state   (lfsr_state),
    .bit_out (phi_bit)
  );

  // NOTE: the sample buffer has no reset; every entry is rewritten before a frame is computed.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) sample_buf[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      row       <= '0;
      col       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid && state != LOAD) overrun <= 1'b1;

      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_ptr == LAST_COL) begin
              wr_ptr <= '0;
              row    <= '0;
              col    <= '0;
              acc    <= '0;
              busy   <= 1'b1;
              state  <= COMPUTE;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        COMPUTE: begin
          acc <= mac_sum;
          col <= col + 1'b1;
          if (col == LAST_COL) begin
            out_data  <= mac_sum;
            out_valid <= 1'b1;
            out_last  <= (row == LAST_ROW);
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (row == LAST_ROW) begin
              out_last <= 1'b0;
              busy     <= 1'b0;
              state    <= LOAD;
            end else begin
              row   <= row + 1'b1;
              col   <= '0;
              acc   <= '0;
              state <= COMPUTE;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_cs_measure_engine.sv
// Randomized self-checking bench for cs_measure_engine against a direct sum-of-products model.
module tb_cs_measure_engine;
  import cs_measure_engine_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_last;
  logic                    busy;
  logic                    overrun;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] frame_x [N];
  int                exp_y   [M];
  int                got_y   [M];

  cs_measure_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Reference: fresh matrix from the seed each frame, y[m] = sum of +/-x[n].
  function automatic void golden();
    logic [15:0] lfsr;
    int          sum;
    lfsr = SEED;
    for (int m = 0; m < M; m++) begin
      sum = 0;
      for (int n = 0; n < N; n++) begin
        if (lfsr[0]) sum = sum + int'(frame_x[n]);
        else         sum = sum - int'(frame_x[n]);
        lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
      end
      exp_y[m] = sum;
    end
  endfunction

  task automatic fill_const(input logic [DATA_W-1:0] c);
    for (int i = 0; i < N; i++) frame_x[i] = c;
    golden();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) frame_x[i] = DATA_W'($urandom);
    golden();
  endtask

  // Leaves in_valid high on the last driven byte.
  task automatic drive_bytes(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame_x[i];
    end
  endtask

  // Counts edges from the last byte to the first out_valid, optionally strobing in_valid mid-compute.
  task automatic finish_frame(input int inject, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = (inject > 0) && (lat >= 10) && (lat < 10 + inject);
      in_data  = DATA_W'($urandom);
    end while (!out_valid && lat < 400);
    in_valid = 1'b0;
    check("latency", lat, N + 1);
  endtask

  task automatic collect(input int rows, input logic [M-1:0] stall);
    int                      cnt;
    logic signed [ACC_W-1:0] hold_d;
    for (int r = 0; r < rows; r++) begin
      cnt = 0;
      while (!out_valid && cnt < 400) begin
        @(negedge clk);
        cnt++;
      end
      check("out_valid_seen", out_valid, 1);
      got_y[r] = int'(out_data);
      check($sformatf("y[%0d]", r), 32'($signed(out_data)), exp_y[r]);
      check($sformatf("last[%0d]", r), out_last, (r == M - 1));
      check("busy_emit", busy, 1);
      if (stall[r]) begin
        out_ready = 1'b0;
        hold_d    = out_data;
        repeat (10) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", 32'($signed(out_data)), 32'($signed(hold_d)));
          check("stall_last", out_last, (r == M - 1));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_drop", out_valid, 0);
    end
    if (rows == M) begin
      check("busy_after_frame", busy, 0);
      check("last_after_frame", out_last, 0);
    end
  endtask

  task automatic run_frame(input logic [M-1:0] stall);
    int lat;
    drive_bytes(0, N);
    finish_frame(0, lat);
    collect(M, stall);
  endtask

  initial begin
    int lat;
    int max_abs;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", 32'($signed(out_data)), 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero frame with exact latency.
    fill_const(8'd0);
    run_frame('0);

    // Constant frames at both ends of the sample range.
    fill_const(8'd1);
    run_frame('0);
    fill_const(8'd255);
    run_frame('0);
    max_abs = 0;
    for (int m = 0; m < M; m++)
      if ((got_y[m] < 0 ? -got_y[m] : got_y[m]) > max_abs) max_abs = (got_y[m] < 0 ? -got_y[m] : got_y[m]);
    check("range255", (max_abs <= 16320), 1);

    // Backpressure on rows 0, 7 and 15.
    fill_random();
    run_frame(16'h8081);

    // Back-to-back frames.
    fill_random();
    run_frame('0);
    fill_random();
    run_frame('0);
    check("overrun_clean", overrun, 0);

    // Strobes during compute are dropped and flagged.
    fill_random();
    drive_bytes(0, N);
    finish_frame(3, lat);
    check("overrun_set", overrun, 1);
    collect(M, '0);
    fill_random();
    drive_bytes(0, N - 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("partial_idle", busy, 0);
    drive_bytes(N - 1, N);
    finish_frame(0, lat);
    collect(M, '0);
    check("overrun_sticky", overrun, 1);

    // Asynchronous reset at row 5, col 30.
    fill_random();
    drive_bytes(0, N);
    finish_frame(0, lat);
    collect(5, '0);
    repeat (30) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", 32'($signed(out_data)), 0);
    check("arst_out_last", out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    fill_random();
    run_frame('0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
